clip_player: RTL and testbench
==============================

Name: clip_player

Overview:
- Sequencer sitting directly upstream of the sound ROM and Audio_Controller.
- On a trigger it walks the ROM address range of one of four stored clips at the audio sample rate.
- It captures each ROM word and hands it to the Audio_Controller with the write_audio_out / audio_out_allowed handshake.
- It replaces the free-running address counter and the hard-wired write enable in the game datapath, and adds one-shot, loop, stop and restart control.

Parameters:
- ADDR_W, 18, ROM address width.
- DATA_W, 6, ROM word width.
- SAMPLE_DIV, 1200, number of cycles spent in PACE per sample. Full sample period is SAMPLE_DIV+2 cycles. Legal values are 2 or more.
- CLIP0_START, 0; CLIP0_END, 16395: win clip.
- CLIP1_START, 16396; CLIP1_END, 66982: moo clip.
- CLIP2_START, 66983; CLIP2_END, 83254: detect clip.
- CLIP3_START, 83255; CLIP3_END, 137138: cheer clip.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- play_req  in  1  one-cycle start/restart pulse.
- clip_sel  in  2  clip index, sampled when play_req is accepted.
- loop  in  1  level input; sampled at each end-of-clip.
- stop  in  1  one-cycle abort pulse.
- rom_addr  out  ADDR_W  address to the sound ROM.
- rom_q  in  DATA_W  ROM data; valid 1 cycle after rom_addr.
- audio_out_allowed  in  1  from Audio_Controller.
- write_audio_out  out  1  write strobe to Audio_Controller.
- sample_out  out  32  left-channel sample, {rom word, zero pad}.
- busy  out  1  high whenever not IDLE.
- done  out  1  one-cycle pulse on non-looping completion.
- drop_cnt  out  8  count of samples never accepted; saturating.

Behaviour:
- Reset values: state IDLE, rom_addr 0, sample_out 0, write_audio_out 0, busy 0, done 0, drop_cnt 0, pending 0, div_cnt 0.
- Priority: reset > stop > play_req > normal progress.
- States: IDLE, PRIME, LATCH, PACE.
- IDLE:
  - On play_req, latch start/end from clip_sel.
  - Set rom_addr <= start and go to PRIME.
  - busy rises the next cycle.
- PRIME: one cycle to cover ROM read latency; always goes to LATCH.
- LATCH:
  - sample_out <= {rom_q, (32-DATA_W) zeros}.
  - pending <= 1, div_cnt <= 0, go to PACE.
- PACE:
  - write_audio_out = pending & audio_out_allowed (combinational from registered pending and state==PACE). pending clears on the cycle the write fires, so at most one write per sample.
  - div_cnt increments each cycle. At div_cnt == SAMPLE_DIV-1, the sample tick occurs.
  - At the tick, if pending is still 1: drop_cnt += 1 (saturates at 255) and pending <= 0.
  - At the tick, if rom_addr != end: rom_addr + 1, go to PRIME.
  - At the tick, if rom_addr == end and loop = 1: rom_addr <= start, go to PRIME. No done pulse.
  - At the tick, if rom_addr == end and loop = 0: done <= 1 for one cycle, go to IDLE. rom_addr and sample_out hold.
- play_req in any non-IDLE state: restart immediately.
  - Relatch the clip, rom_addr <= new start, pending <= 0, go to PRIME.
  - An unsent sample is discarded without counting as a drop.
- stop in any state: go to IDLE, pending <= 0, sample_out <= 0, no done pulse. stop in IDLE has no effect except clearing sample_out.
- stop and play_req in the same cycle: stop wins.
- Reset mid-clip: all registers return to reset values on the next edge. A write_audio_out already high that cycle is the last one.
- A single-word clip (start == end) plays one sample, then completes or loops.
- rom_addr never leaves [start, end] of the active clip.

Optional Feature:
- Macro: CLIP_PLAYER_VOLUME_EN.
- When defined: adds input volume[1:0]. At LATCH, sample_out becomes the padded word arithmetically right-shifted by volume (0 = full, 3 = 1/8). volume is sampled at LATCH.
- When undefined: no volume port; sample_out is the unshifted padded word.

Test Plan (bench uses SAMPLE_DIV=4 and a model ROM returning q = address[5:0]):
- play_req with clip_sel=2, loop=0, audio_out_allowed held 1:
  - Addresses 66983..83254 are issued in order, one every 6 cycles.
  - Exactly 16272 write strobes occur, each with sample_out[31:26] = addr[5:0].
  - Then one done pulse, then busy=0.
- clip_sel=0, loop=1: after addr 16395, rom_addr returns to 0 with no done pulse, and busy stays 1 across 3 loops.
- audio_out_allowed held 0 for a full clip-3 play:
  - write_audio_out never asserts.
  - drop_cnt saturates at 255 and does not wrap.
- play_req with clip_sel=1 issued mid-clip-0 (rom_addr=100): next issued address is 16396 (PRIME), and no done pulse occurs.
- stop and play_req in the same cycle mid-clip: state IDLE, sample_out=0, busy=0 next cycle, no done pulse.
- reset asserted during PACE with pending=1: next cycle all outputs are at reset values, and there is no further write_audio_out.

Source files
------------

// File: rtl/clip_player.sv
`default_nettype none
// ============================================================================
// Module   : clip_player
// Purpose  : Plays one of four ROM-resident sound clips at the audio sample
//            rate into the Audio_Controller. Supports one-shot, loop, stop and
//            restart. Optional volume shift when CLIP_PLAYER_VOLUME_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module clip_player #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 6,
  parameter int SAMPLE_DIV  = 1200,
  parameter int CLIP0_START = 0,
  parameter int CLIP0_END   = 16395,
  parameter int CLIP1_START = 16396,
  parameter int CLIP1_END   = 66982,
  parameter int CLIP2_START = 66983,
  parameter int CLIP2_END   = 83254,
  parameter int CLIP3_START = 83255,
  parameter int CLIP3_END   = 137138
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              play_req,
  input  logic [1:0]        clip_sel,
  input  logic              loop,
  input  logic              stop,
`ifdef CLIP_PLAYER_VOLUME_EN
  input  logic [1:0]        volume,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  input  logic              audio_out_allowed,
  output logic              write_audio_out,
  output logic [31:0]       sample_out,
  output logic              busy,
  output logic              done,
  output logic [7:0]        drop_cnt
);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_PRIME = 2'd1;
  localparam logic [1:0] c_S_LATCH = 2'd2;
  localparam logic [1:0] c_S_PACE  = 2'd3;

  localparam int                  c_DIV_W    = $clog2(SAMPLE_DIV);
  localparam logic [c_DIV_W-1:0]  c_DIV_LAST = c_DIV_W'(SAMPLE_DIV - 1);

  logic [1:0]         r_state;
  logic [ADDR_W-1:0]  r_start;
  logic [ADDR_W-1:0]  r_end;
  logic               r_pending;
  logic [c_DIV_W-1:0] r_div_cnt;

  logic [ADDR_W-1:0]  w_sel_start;
  logic [ADDR_W-1:0]  w_sel_end;
  logic [31:0]        w_padded;
  logic [31:0]        w_sample;
  logic               w_tick;

  always_comb begin
    w_sel_start = ADDR_W'(CLIP0_START);
    w_sel_end   = ADDR_W'(CLIP0_END);
    case (clip_sel)
      2'd1: begin
        w_sel_start = ADDR_W'(CLIP1_START);
        w_sel_end   = ADDR_W'(CLIP1_END);
      end
      2'd2: begin
        w_sel_start = ADDR_W'(CLIP2_START);
        w_sel_end   = ADDR_W'(CLIP2_END);
      end
      2'd3: begin
        w_sel_start = ADDR_W'(CLIP3_START);
        w_sel_end   = ADDR_W'(CLIP3_END);
      end
      default: ;
    endcase
  end

  assign w_padded = {rom_q, {(32-DATA_W){1'b0}}};
`ifdef CLIP_PLAYER_VOLUME_EN
  // Arithmetic shift keeps the sign of the audio word while attenuating.
  assign w_sample = 32'($signed(w_padded) >>> volume);
`else
  assign w_sample = w_padded;
`endif

  assign w_tick          = (r_div_cnt == c_DIV_LAST);
  assign write_audio_out = (r_state == c_S_PACE) & r_pending & audio_out_allowed;
  assign busy            = (r_state != c_S_IDLE);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state    <= c_S_IDLE;
      r_start    <= '0;
      r_end      <= '0;
      r_pending  <= 1'b0;
      r_div_cnt  <= '0;
      rom_addr   <= '0;
      sample_out <= '0;
      done       <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        r_state    <= c_S_IDLE;
        r_pending  <= 1'b0;
        sample_out <= '0;
      end else if (play_req) begin
        // Restart from any state; an unsent sample is silently discarded.
        r_start   <= w_sel_start;
        r_end     <= w_sel_end;
        rom_addr  <= w_sel_start;
        r_pending <= 1'b0;
        r_state   <= c_S_PRIME;
      end else begin
        case (r_state)
          c_S_PRIME: r_state <= c_S_LATCH;
          c_S_LATCH: begin
            sample_out <= w_sample;
            r_pending  <= 1'b1;
            r_div_cnt  <= '0;
            r_state    <= c_S_PACE;
          end
          c_S_PACE: begin
            r_div_cnt <= r_div_cnt + 1'b1;
            if (write_audio_out) begin
              r_pending <= 1'b0;
            end
            if (w_tick) begin
              // A sample still unsent at the end of its slot is lost.
              if (r_pending && !write_audio_out) begin
                r_pending <= 1'b0;
                if (drop_cnt != 8'hFF) begin
                  drop_cnt <= drop_cnt + 8'd1;
                end
              end
              if (rom_addr != r_end) begin
                rom_addr <= rom_addr + 1'b1;
                r_state  <= c_S_PRIME;
              end else if (loop) begin
                rom_addr <= r_start;
                r_state  <= c_S_PRIME;
              end else begin
                done    <= 1'b1;
                r_state <= c_S_IDLE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clip_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_clip_player
// Purpose  : Directed self-checking bench for clip_player using short clips,
//            SAMPLE_DIV=4 (6-cycle sample period) and a ROM model q=addr[5:0].
// Revision : 1.0 - initial release
// ============================================================================
module tb_clip_player;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 6;
  localparam int DIV    = 4;
  localparam int PERIOD = DIV + 2;

  // Clip 1 is a single-word clip; clip 3 is long enough to saturate drop_cnt.
  localparam int C0S = 0,   C0E = 119;
  localparam int C1S = 120, C1E = 120;
  localparam int C2S = 121, C2E = 136;
  localparam int C3S = 137, C3E = 436;

  logic              CLOCK_50 = 1'b0;
  logic              reset;
  logic              play_req;
  logic [1:0]        clip_sel;
  logic              loop;
  logic              stop;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q = '0;
  logic              audio_out_allowed;
  logic              write_audio_out;
  logic [31:0]       sample_out;
  logic              busy;
  logic              done;
  logic [7:0]        drop_cnt;
`ifdef CLIP_PLAYER_VOLUME_EN
  logic [1:0]        volume = 2'd0;
`endif

  clip_player #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SAMPLE_DIV(DIV),
    .CLIP0_START(C0S), .CLIP0_END(C0E), .CLIP1_START(C1S), .CLIP1_END(C1E),
    .CLIP2_START(C2S), .CLIP2_END(C2E), .CLIP3_START(C3S), .CLIP3_END(C3E)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .play_req(play_req),
    .clip_sel(clip_sel), .loop(loop), .stop(stop),
`ifdef CLIP_PLAYER_VOLUME_EN
    .volume(volume),
`endif
    .rom_addr(rom_addr), .rom_q(rom_q),
    .audio_out_allowed(audio_out_allowed), .write_audio_out(write_audio_out),
    .sample_out(sample_out), .busy(busy), .done(done), .drop_cnt(drop_cnt)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) rom_q <= rom_addr[5:0];

  int n_checks = 0;
  int n_fail   = 0;

  int                cyc = 0;
  int                wr_cnt = 0;
  int                wr_bad = 0;
  int                done_cnt = 0;
  logic [ADDR_W-1:0] wr_addr_q[$];
  int                wr_cyc_q[$];

  always @(negedge CLOCK_50) begin
    cyc++;
    if (write_audio_out) begin
      wr_cnt++;
      wr_addr_q.push_back(rom_addr);
      wr_cyc_q.push_back(cyc);
      if (sample_out !== {rom_addr[5:0], 26'd0}) wr_bad++;
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic play(input logic [1:0] sel, input logic lp);
    clip_sel = sel;
    loop     = lp;
    play_req = 1'b1;
    step(1);
    play_req = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string tag);
    int k;
    k = 0;
    while (!done && k < limit) begin
      step(1);
      k++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int base_w, base_d, bad, wraps, nbusy, oor, k;
    logic [ADDR_W-1:0] prev;

    reset = 1'b1; play_req = 1'b0; clip_sel = 2'd0; loop = 1'b0; stop = 1'b0;
    audio_out_allowed = 1'b1;
    step(3);
    check("rst_addr",   32'(rom_addr), 32'd0);
    check("rst_sample", sample_out, 32'd0);
    check("rst_write",  32'(write_audio_out), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_drop",   32'(drop_cnt), 32'd0);
    reset = 1'b0;
    step(1);

    // One-shot play of clip 2 with the controller always ready.
    base_w = wr_cnt; base_d = done_cnt;
    play(2'd2, 1'b0);
    check("t1_busy_rise", 32'(busy), 32'd1);
    check("t1_first_addr", 32'(rom_addr), 32'(C2S));
    wait_done(16 * PERIOD + 20, "t1_done");
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_addr_hold", 32'(rom_addr), 32'(C2E));
    step(1);
    check("t1_done_1cyc", 32'(done), 32'd0);
    check("t1_writes", 32'(wr_cnt - base_w), 32'd16);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (wr_addr_q[base_w + i] !== ADDR_W'(C2S + i)) bad++;
      if (i > 0 && (wr_cyc_q[base_w + i] - wr_cyc_q[base_w + i - 1]) != PERIOD) bad++;
    end
    check("t1_seq", 32'(bad), 32'd0);
    check("t1_done_cnt", 32'(done_cnt - base_d), 32'd1);

    // Looping clip 0: three wraps back to the start, never idle, never done.
    base_d = done_cnt;
    play(2'd0, 1'b1);
    prev = rom_addr; wraps = 0; nbusy = 0; oor = 0;
    for (int i = 0; i < 3 * 120 * PERIOD + 30; i++) begin
      step(1);
      if (prev == ADDR_W'(C0E) && rom_addr == ADDR_W'(C0S)) wraps++;
      if (!busy) nbusy++;
      if (rom_addr > ADDR_W'(C0E)) oor++;
      prev = rom_addr;
    end
    check("t2_wraps", 32'(wraps), 32'd3);
    check("t2_busy", 32'(nbusy), 32'd0);
    check("t2_range", 32'(oor), 32'd0);
    check("t2_no_done", 32'(done_cnt - base_d), 32'd0);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("t2_stop_busy", 32'(busy), 32'd0);
    check("t2_stop_sample", sample_out, 32'd0);
    step(5);
    check("t2_stop_no_done", 32'(done_cnt - base_d), 32'd0);

    // Restart into single-word clip 1 from the middle of clip 0.
    play(2'd0, 1'b0);
    k = 0;
    while (rom_addr != ADDR_W'(100) && k < 101 * PERIOD + 20) begin
      step(1);
      k++;
    end
    check("t3_reach100", 32'(rom_addr), 32'd100);
    step(3);
    base_d = done_cnt;
    clip_sel = 2'd1; play_req = 1'b1;
    step(1);
    play_req = 1'b0;
    base_w = wr_cnt;
    check("t3_restart_addr", 32'(rom_addr), 32'(C1S));
    check("t3_restart_busy", 32'(busy), 32'd1);
    wait_done(3 * PERIOD, "t3_done");
    step(1);
    check("t3_writes", 32'(wr_cnt - base_w), 32'd1);
    check("t3_write_addr", 32'(wr_addr_q[base_w]), 32'(C1S));
    check("t3_done_cnt", 32'(done_cnt - base_d), 32'd1);

    // Stop and play in the same cycle: stop wins.
    play(2'd3, 1'b0);
    step(20);
    base_d = done_cnt;
    stop = 1'b1; play_req = 1'b1; clip_sel = 2'd2;
    step(1);
    stop = 1'b0; play_req = 1'b0;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_sample", sample_out, 32'd0);
    step(5);
    check("t4_still_idle", 32'(busy), 32'd0);
    check("t4_no_done", 32'(done_cnt - base_d), 32'd0);

    // Controller never ready for 300 samples: drop_cnt saturates at 255.
    check("t5_drop_start", 32'(drop_cnt), 32'd0);
    audio_out_allowed = 1'b0;
    base_w = wr_cnt; base_d = done_cnt;
    play(2'd3, 1'b0);
    wait_done(300 * PERIOD + 30, "t5_done");
    step(1);
    check("t5_drop_sat", 32'(drop_cnt), 32'd255);
    check("t5_no_write", 32'(wr_cnt - base_w), 32'd0);
    check("t5_done_cnt", 32'(done_cnt - base_d), 32'd1);

    // Reset while a sample is pending in PACE.
    play(2'd2, 1'b0);
    step(2);
    audio_out_allowed = 1'b1;
    #1;
    check("t6_write_pre", 32'(write_audio_out), 32'd1);
    reset = 1'b1;
    step(1);
    check("t6_write", 32'(write_audio_out), 32'd0);
    check("t6_addr", 32'(rom_addr), 32'd0);
    check("t6_sample", sample_out, 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_drop", 32'(drop_cnt), 32'd0);
    reset = 1'b0;
    base_w = wr_cnt;
    step(10);
    check("t6_no_more_write", 32'(wr_cnt - base_w), 32'd0);

    check("wr_data", 32'(wr_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
